// File: rtl/multicycle_ctrl_v2.sv
// Multi-cycle control FSM for the group processor: fetch/decode/execute with memory handshake and HALT/resume.
// Optional performance counters are enabled with the CTRL_PERF_CNT_EN macro.
module multicycle_ctrl_v2 #(
  parameter int OP_W   = 4,
  parameter int CC_W   = 4,
  parameter int PERF_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [OP_W-1:0]   OPCODE,
  input  logic [CC_W-1:0]   MM,
  input  logic [CC_W-1:0]   STAT,
  input  logic              MEM_ACK,
  input  logic              RESUME,
  output logic              PC_RST,
  output logic              PC_WRITE,
  output logic              PC_SEL,
  output logic              BR_SEL,
  output logic              IR_WE,
  output logic              RD_SEL,
  output logic [1:0]        ALU_OP,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic              RF_WE,
  output logic              WB_SEL,
  output logic              HALTED,
  output logic [PERF_W-1:0] CYC_CNT,
  output logic [PERF_W-1:0] RET_CNT
);

  localparam logic [OP_W-1:0] OP_NOP = OP_W'(4'd0);
  localparam logic [OP_W-1:0] OP_LOD = OP_W'(4'd1);
  localparam logic [OP_W-1:0] OP_STR = OP_W'(4'd2);
  localparam logic [OP_W-1:0] OP_BRA = OP_W'(4'd4);
  localparam logic [OP_W-1:0] OP_BRR = OP_W'(4'd5);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(4'd6);
  localparam logic [OP_W-1:0] OP_ALU = OP_W'(4'd8);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'd15);
  localparam logic [CC_W-1:0] MM_IMM = CC_W'(4'd8);

  typedef enum logic [2:0] {
    ST_START0  = 3'd0,
    ST_START1  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_DECODE  = 3'd3,
    ST_EXECUTE = 3'd4,
    ST_MEM     = 3'd5,
    ST_WB      = 3'd6,
    ST_HALT    = 3'd7
  } state_e;

  state_e state_q;
  state_e state_d;

  logic cond_hit_s;
  logic imm_mode_s;

  assign cond_hit_s = ((MM & STAT) != {CC_W{1'b0}});
  assign imm_mode_s = (MM == MM_IMM);

  // State register; reset overrides any pending memory wait or resume.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_START0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d  = state_q;
    PC_RST   = 1'b0;
    PC_WRITE = 1'b0;
    PC_SEL   = 1'b0;
    BR_SEL   = 1'b0;
    IR_WE    = 1'b0;
    RD_SEL   = 1'b0;
    ALU_OP   = 2'b00;
    MEM_REQ  = 1'b0;
    MEM_WE   = 1'b0;
    RF_WE    = 1'b0;
    WB_SEL   = 1'b0;
    HALTED   = 1'b0;
    case (state_q)
      ST_START0: begin
        PC_RST  = 1'b1;
        state_d = ST_START1;
      end
      ST_START1: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        PC_WRITE = 1'b1;
        IR_WE    = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        RD_SEL = (OPCODE == OP_ALU) && imm_mode_s;
        if (OPCODE == OP_HLT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        case (OPCODE)
          OP_ALU: begin
            ALU_OP  = imm_mode_s ? 2'b01 : 2'b00;
            state_d = ST_WB;
          end
          OP_LOD, OP_STR: begin
            RD_SEL  = 1'b1;
            ALU_OP  = 2'b01;
            state_d = ST_MEM;
          end
          OP_BRA, OP_BRR: begin
            if (cond_hit_s) begin
              PC_WRITE = 1'b1;
              PC_SEL   = 1'b1;
              BR_SEL   = (OPCODE == OP_BRA);
              ALU_OP   = 2'b10;
            end else begin
              PC_SEL   = 1'b0;
            end
            state_d = ST_FETCH;
          end
          OP_BNE: begin
            if (!cond_hit_s) begin
              PC_WRITE = 1'b1;
              PC_SEL   = 1'b1;
              BR_SEL   = 1'b1;
              ALU_OP   = 2'b10;
            end else begin
              PC_SEL   = 1'b0;
            end
            state_d = ST_FETCH;
          end
          OP_NOP: begin
            state_d = ST_FETCH;
          end
          default: begin
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        MEM_REQ = 1'b1;
        MEM_WE  = (OPCODE == OP_STR);
        if (MEM_ACK) begin
          state_d = (OPCODE == OP_LOD) ? ST_WB : ST_FETCH;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        RF_WE   = 1'b1;
        WB_SEL  = (OPCODE == OP_LOD);
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        HALTED = 1'b1;
        if (RESUME) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_START0;
      end
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic              retire_s;
  logic [PERF_W-1:0] cyc_cnt_q;
  logic [PERF_W-1:0] cyc_cnt_d;
  logic [PERF_W-1:0] ret_cnt_q;
  logic [PERF_W-1:0] ret_cnt_d;

  // An instruction retires in its last state before FETCH; HLT retires as it enters HALT.
  always_comb begin
    retire_s = 1'b0;
    case (state_q)
      ST_EXECUTE, ST_MEM, ST_WB: retire_s = (state_d == ST_FETCH);
      ST_DECODE:                 retire_s = (state_d == ST_HALT);
      default:                   retire_s = 1'b0;
    endcase
  end

  // Counter next values; both hold while halted.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (state_q != ST_HALT) begin
      cyc_cnt_d = cyc_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
      ret_cnt_d = ret_cnt_q + {{(PERF_W-1){1'b0}}, retire_s};
    end else begin
      cyc_cnt_d = cyc_cnt_q;
      ret_cnt_d = ret_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cyc_cnt_q <= {PERF_W{1'b0}};
      ret_cnt_q <= {PERF_W{1'b0}};
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign CYC_CNT = cyc_cnt_q;
  assign RET_CNT = ret_cnt_q;
`else
  assign CYC_CNT = {PERF_W{1'b0}};
  assign RET_CNT = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Table-driven, cycle-by-cycle bench for multicycle_ctrl_v2 with a scoreboard queue of expected outputs.
module tb_multicycle_ctrl_v2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  OPCODE, MM, STAT;
  logic        MEM_ACK, RESUME;
  logic        PC_RST, PC_WRITE, PC_SEL, BR_SEL, IR_WE, RD_SEL;
  logic [1:0]  ALU_OP;
  logic        MEM_REQ, MEM_WE, RF_WE, WB_SEL, HALTED;
  logic [15:0] CYC_CNT, RET_CNT;

  multicycle_ctrl_v2 #(.OP_W(4), .CC_W(4), .PERF_W(16)) dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE), .MM(MM), .STAT(STAT),
    .MEM_ACK(MEM_ACK), .RESUME(RESUME),
    .PC_RST(PC_RST), .PC_WRITE(PC_WRITE), .PC_SEL(PC_SEL), .BR_SEL(BR_SEL),
    .IR_WE(IR_WE), .RD_SEL(RD_SEL), .ALU_OP(ALU_OP), .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE), .RF_WE(RF_WE), .WB_SEL(WB_SEL), .HALTED(HALTED),
    .CYC_CNT(CYC_CNT), .RET_CNT(RET_CNT)
  );

  always #5 CLK = ~CLK;

  // Output bundle: {PC_RST,PC_WRITE,PC_SEL,BR_SEL,IR_WE,RD_SEL,ALU_OP,MEM_REQ,MEM_WE,RF_WE,WB_SEL,HALTED}
  localparam logic [12:0] O_NONE   = 13'h0000;
  localparam logic [12:0] O_PCRST  = 13'h1000;
  localparam logic [12:0] O_FETCH  = 13'h0900;
  localparam logic [12:0] O_DECIMM = 13'h0080;
  localparam logic [12:0] O_ALUI   = 13'h0020;
  localparam logic [12:0] O_EXMEM  = 13'h00A0;
  localparam logic [12:0] O_BRABS  = 13'h0E40;
  localparam logic [12:0] O_BRREL  = 13'h0C40;
  localparam logic [12:0] O_MEMRD  = 13'h0010;
  localparam logic [12:0] O_MEMWR  = 13'h0018;
  localparam logic [12:0] O_WBALU  = 13'h0004;
  localparam logic [12:0] O_WBLOD  = 13'h0006;
  localparam logic [12:0] O_HALT   = 13'h0001;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic [3:0]  mm;
    logic [3:0]  stat;
    logic        ack;
    logic        res;
    logic [12:0] exp;
    logic        ret;
  } vec_t;

  typedef struct {
    logic [12:0] o;
    logic [15:0] cyc;
    logic [15:0] ret;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_cyc = 16'd0;
  logic [15:0] exp_ret = 16'd0;

  function automatic void add(input logic rst, input logic [3:0] op, input logic [3:0] mm,
                              input logic [3:0] stat, input logic ack, input logic res,
                              input logic [12:0] exp, input logic ret);
    vec_t v;
    v.rst = rst; v.op = op; v.mm = mm; v.stat = stat;
    v.ack = ack; v.res = res; v.exp = exp; v.ret = ret;
    vecs.push_back(v);
  endfunction

  initial begin
    sb_t         e;
    logic [12:0] act;
    logic [15:0] want_cyc, want_ret;

    // Reset, then ALU immediate: PC_RST in cycle 0, FETCH at 2, WB at 5, FETCH at 6
    add(0, 4'd8, 4'd8, 4'd0, 0, 0, O_PCRST,  0);
    add(0, 4'd8, 4'd8, 4'd0, 0, 0, O_NONE,   0);
    add(0, 4'd8, 4'd8, 4'd0, 0, 0, O_FETCH,  0);
    add(0, 4'd8, 4'd8, 4'd0, 0, 0, O_DECIMM, 0);
    add(0, 4'd8, 4'd8, 4'd0, 0, 0, O_ALUI,   0);
    add(0, 4'd8, 4'd8, 4'd0, 0, 0, O_WBALU,  1);
    add(0, 4'd8, 4'd3, 4'd0, 0, 0, O_FETCH,  0);
    // ALU register mode
    add(0, 4'd8, 4'd3, 4'd0, 0, 0, O_NONE,   0);
    add(0, 4'd8, 4'd3, 4'd0, 0, 0, O_NONE,   0);
    add(0, 4'd8, 4'd3, 4'd0, 0, 0, O_WBALU,  1);
    add(0, 4'd6, 4'd2, 4'd4, 0, 0, O_FETCH,  0);
    // BNE taken (mask & stat == 0), then not taken
    add(0, 4'd6, 4'd2, 4'd4, 0, 0, O_NONE,   0);
    add(0, 4'd6, 4'd2, 4'd4, 0, 0, O_BRABS,  1);
    add(0, 4'd6, 4'd2, 4'd2, 0, 0, O_FETCH,  0);
    add(0, 4'd6, 4'd2, 4'd2, 0, 0, O_NONE,   0);
    add(0, 4'd6, 4'd2, 4'd2, 0, 0, O_NONE,   1);
    // BRR taken (relative), BRA not taken, BRA taken
    add(0, 4'd5, 4'd1, 4'd1, 0, 0, O_FETCH,  0);
    add(0, 4'd5, 4'd1, 4'd1, 0, 0, O_NONE,   0);
    add(0, 4'd5, 4'd1, 4'd1, 0, 0, O_BRREL,  1);
    add(0, 4'd4, 4'd1, 4'd0, 0, 0, O_FETCH,  0);
    add(0, 4'd4, 4'd1, 4'd0, 0, 0, O_NONE,   0);
    add(0, 4'd4, 4'd1, 4'd0, 0, 0, O_NONE,   1);
    add(0, 4'd4, 4'd3, 4'd2, 0, 0, O_FETCH,  0);
    add(0, 4'd4, 4'd3, 4'd2, 0, 0, O_NONE,   0);
    add(0, 4'd4, 4'd3, 4'd2, 0, 0, O_BRABS,  1);
    // NOP
    add(0, 4'd0, 4'd0, 4'd0, 0, 0, O_FETCH,  0);
    add(0, 4'd0, 4'd0, 4'd0, 0, 0, O_NONE,   0);
    add(0, 4'd0, 4'd0, 4'd0, 0, 0, O_NONE,   1);
    // LOD with MM=8 (no RD_SEL in DECODE), MEM_ACK after 3 wait cycles
    add(0, 4'd1, 4'd8, 4'd0, 0, 0, O_FETCH,  0);
    add(0, 4'd1, 4'd8, 4'd0, 0, 0, O_NONE,   0);
    add(0, 4'd1, 4'd8, 4'd0, 0, 0, O_EXMEM,  0);
    add(0, 4'd1, 4'd8, 4'd0, 0, 0, O_MEMRD,  0);
    add(0, 4'd1, 4'd8, 4'd0, 0, 0, O_MEMRD,  0);
    add(0, 4'd1, 4'd8, 4'd0, 0, 0, O_MEMRD,  0);
    add(0, 4'd1, 4'd8, 4'd0, 1, 0, O_MEMRD,  0);
    add(0, 4'd1, 4'd8, 4'd0, 0, 0, O_WBLOD,  1);
    // STR with MEM_ACK held high throughout (ignored outside MEM)
    add(0, 4'd2, 4'd0, 4'd0, 1, 0, O_FETCH,  0);
    add(0, 4'd2, 4'd0, 4'd0, 1, 0, O_NONE,   0);
    add(0, 4'd2, 4'd0, 4'd0, 1, 0, O_EXMEM,  0);
    add(0, 4'd2, 4'd0, 4'd0, 1, 0, O_MEMWR,  1);
    // Undefined opcode behaves like NOP
    add(0, 4'd3, 4'd0, 4'd0, 1, 0, O_FETCH,  0);
    add(0, 4'd3, 4'd0, 4'd0, 0, 0, O_NONE,   0);
    add(0, 4'd3, 4'd0, 4'd0, 0, 0, O_NONE,   1);
    // HLT, 10 idle halted cycles, RESUME pulse
    add(0, 4'd15, 4'd0, 4'd0, 0, 0, O_FETCH, 0);
    add(0, 4'd15, 4'd0, 4'd0, 0, 0, O_NONE,  1);
    for (int k = 0; k < 10; k++) add(0, 4'd15, 4'd0, 4'd0, 0, 0, O_HALT, 0);
    add(0, 4'd15, 4'd0, 4'd0, 0, 1, O_HALT,  0);
    add(0, 4'd15, 4'd0, 4'd0, 0, 0, O_FETCH, 0);
    // HLT again; RST and RESUME together -> reset wins
    add(0, 4'd15, 4'd0, 4'd0, 0, 0, O_NONE,  1);
    add(0, 4'd15, 4'd0, 4'd0, 0, 0, O_HALT,  0);
    add(1, 4'd15, 4'd0, 4'd0, 0, 1, O_HALT,  0);
    add(0, 4'd1, 4'd0, 4'd0, 0, 0, O_PCRST,  0);
    add(0, 4'd1, 4'd0, 4'd0, 0, 0, O_NONE,   0);
    // RST pulse during LOD memory wait
    add(0, 4'd1, 4'd0, 4'd0, 0, 0, O_FETCH,  0);
    add(0, 4'd1, 4'd0, 4'd0, 0, 0, O_NONE,   0);
    add(0, 4'd1, 4'd0, 4'd0, 0, 0, O_EXMEM,  0);
    add(0, 4'd1, 4'd0, 4'd0, 0, 0, O_MEMRD,  0);
    add(1, 4'd1, 4'd0, 4'd0, 0, 0, O_MEMRD,  0);
    add(0, 4'd1, 4'd0, 4'd0, 0, 0, O_PCRST,  0);
    add(0, 4'd1, 4'd0, 4'd0, 0, 0, O_NONE,   0);
    add(0, 4'd1, 4'd0, 4'd0, 0, 0, O_FETCH,  0);

    RST = 1'b1; OPCODE = 4'd0; MM = 4'd0; STAT = 4'd0; MEM_ACK = 1'b0; RESUME = 1'b0;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge CLK);
      #1;
      RST = vecs[i].rst; OPCODE = vecs[i].op; MM = vecs[i].mm; STAT = vecs[i].stat;
      MEM_ACK = vecs[i].ack; RESUME = vecs[i].res;
`ifdef CTRL_PERF_CNT_EN
      want_cyc = exp_cyc; want_ret = exp_ret;
`else
      want_cyc = 16'd0; want_ret = 16'd0;
`endif
      sb_q.push_back('{o: vecs[i].exp, cyc: want_cyc, ret: want_ret});
      @(negedge CLK);
      e   = sb_q.pop_front();
      act = {PC_RST, PC_WRITE, PC_SEL, BR_SEL, IR_WE, RD_SEL, ALU_OP,
             MEM_REQ, MEM_WE, RF_WE, WB_SEL, HALTED};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL ctrl_out row %0d: got %013b expected %013b", i, act, e.o);
      end
      checks++;
      if (CYC_CNT !== e.cyc || RET_CNT !== e.ret) begin
        errors++;
        $display("FAIL perf_cnt row %0d: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                 i, CYC_CNT, RET_CNT, e.cyc, e.ret);
      end
      if (vecs[i].rst) begin
        exp_cyc = 16'd0;
        exp_ret = 16'd0;
      end else if (!vecs[i].exp[0]) begin
        exp_cyc = exp_cyc + 16'd1;
        if (vecs[i].ret) exp_ret = exp_ret + 16'd1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
